sm83_regbank: RTL and testbench

//  Parametrised register-pair bank with integrated address latch and inc/dec unit for sm83-family cores.

---
 rtl/sm83_pkg.sv | 24 ++
 rtl/sm83_incdec.sv | 22 ++
 rtl/sm83_regbank.sv | 146 ++++++++++++++
 tb/tb_sm83_regbank.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm83_pkg.sv
// Shared types and constants for the sm83 register bank: word/pair types,
// inc/dec mode encoding and the conventional register-pair indices.
package sm83_pkg;

  localparam int WORD_SIZE_DEF = 8;

  typedef logic [WORD_SIZE_DEF-1:0]   word_t;
  typedef logic [2*WORD_SIZE_DEF-1:0] pair_t;

  typedef enum logic [1:0] {
    INC_HOLD  = 2'd0,
    INC_UP    = 2'd1,
    INC_DOWN  = 2'd2,
    INC_LATCH = 2'd3
  } inc_mode_t;

  localparam int BC = 0;
  localparam int DE = 1;
  localparam int HL = 2;
  localparam int AF = 3;
  localparam int SP = 4;
  localparam int PC = 5;

endpackage

// File: rtl/sm83_incdec.sv
// Combinational +/-1 unit for a register pair, with a wrap flag raised on
// +1 from all-ones or -1 from zero.
module sm83_incdec #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_down,
  output logic [WIDTH-1:0] o_val,
  output logic             o_wrap
);

  always_comb begin
    if (i_down) begin
      o_val  = i_val - WIDTH'(1);
      o_wrap = (i_val == '0);
    end else begin
      o_val  = i_val + WIDTH'(1);
      o_wrap = &i_val;
    end
  end

endmodule

// File: rtl/sm83_regbank.sv
// Register-pair bank with address latch and two-phase inc/dec sequencer.
// Define SM83_REGBANK_ALT_EN to build the shadow (alternate) register set.
module sm83_regbank
  import sm83_pkg::*;
#(
  parameter int                   WORD_SIZE = WORD_SIZE_DEF,
  parameter int                   NUM_PAIRS = 6,
  parameter int                   AF_IDX    = AF,
  parameter logic [WORD_SIZE-1:0] FLAG_MASK = 'hF0,
  parameter int                   NUM_ALT   = 3,
  localparam int                  SEL_W     = $clog2(NUM_PAIRS),
  localparam int                  PW        = 2 * WORD_SIZE
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [PW-1:0]    rd_pair,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic             wr_hi_we,
  input  logic             wr_lo_we,
  input  logic [PW-1:0]    wr_data,
  input  logic             inc_start,
  input  logic [SEL_W-1:0] inc_sel,
  input  logic [1:0]       inc_mode,
  output logic             inc_busy,
  output logic             inc_carry,
  output logic [PW-1:0]    al_out,
  input  logic             alt_swap
);

  typedef enum logic {ST_IDLE, ST_WB} state_t;

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_pairs     [NUM_PAIRS];
  logic [PW-1:0]    w_pairs_nxt [NUM_PAIRS];
  logic [PW-1:0]    r_al;
  logic [SEL_W-1:0] r_sel;
  logic             r_down;
  logic             r_carry;
  logic [PW-1:0]    w_inc_val;
  logic             w_inc_wrap;
  logic             w_start;
  logic             w_modify;
  logic             w_do_swap;
  inc_mode_t        w_mode;

  function automatic logic sel_ok(input logic [SEL_W-1:0] s);
    return int'(s) < NUM_PAIRS;
  endfunction

  assign rd_pair   = sel_ok(rd_sel) ? r_pairs[rd_sel] : '0;
  assign inc_busy  = (r_state == ST_WB);
  assign inc_carry = r_carry;
  assign al_out    = r_al;

  assign w_mode   = inc_mode_t'(inc_mode);
  assign w_modify = (w_mode == INC_UP) || (w_mode == INC_DOWN);
  assign w_start  = inc_start && (r_state == ST_IDLE) && sel_ok(inc_sel);

  sm83_incdec #(.WIDTH(PW)) u_incdec (
    .i_val  (r_al),
    .i_down (r_down),
    .o_val  (w_inc_val),
    .o_wrap (w_inc_wrap)
  );

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start && w_modify) w_state_nxt = ST_WB;
      ST_WB:   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef SM83_REGBANK_ALT_EN
  logic [PW-1:0] r_shadow [NUM_ALT];
  logic          r_swap_pend;

  // A swap requested during write-back waits one cycle so it never races the inc result.
  assign w_do_swap = (alt_swap || r_swap_pend) && (r_state == ST_IDLE);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NUM_ALT; i++) r_shadow[i] <= '0;
      r_swap_pend <= 1'b0;
    end else begin
      if (w_do_swap) begin
        for (int i = 0; i < NUM_ALT; i++) r_shadow[i] <= r_pairs[i];
      end
      r_swap_pend <= alt_swap && (r_state == ST_WB);
    end
  end
`else
  logic w_unused_swap;
  localparam int unused_num_alt = NUM_ALT;
  assign w_unused_swap = alt_swap;
  assign w_do_swap     = 1'b0;
`endif

  // Priority, lowest first: swap, inc write-back, write port (per byte).
  always_comb begin
    for (int i = 0; i < NUM_PAIRS; i++) begin
      w_pairs_nxt[i] = r_pairs[i];
`ifdef SM83_REGBANK_ALT_EN
      if (w_do_swap && (i < NUM_ALT)) w_pairs_nxt[i] = r_shadow[i];
`endif
      if ((r_state == ST_WB) && (r_sel == SEL_W'(i))) w_pairs_nxt[i] = w_inc_val;
      if (sel_ok(wr_sel) && (wr_sel == SEL_W'(i))) begin
        if (wr_hi_we) w_pairs_nxt[i][PW-1:WORD_SIZE] = wr_data[PW-1:WORD_SIZE];
        if (wr_lo_we) w_pairs_nxt[i][WORD_SIZE-1:0] = wr_data[WORD_SIZE-1:0];
      end
      if (i == AF_IDX) w_pairs_nxt[i][WORD_SIZE-1:0] = w_pairs_nxt[i][WORD_SIZE-1:0] & FLAG_MASK;
    end
  end

  // NOTE: the register file is reset explicitly because software relies on all pairs reading 0.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NUM_PAIRS; i++) r_pairs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PAIRS; i++) r_pairs[i] <= w_pairs_nxt[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= ST_IDLE;
      r_al    <= '0;
      r_sel   <= '0;
      r_down  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_al   <= r_pairs[inc_sel];
        r_sel  <= inc_sel;
        r_down <= (w_mode == INC_DOWN);
      end
      if (r_state == ST_WB) r_carry <= w_inc_wrap;
    end
  end

endmodule

// File: tb/tb_sm83_regbank.sv
// Self-checking bench for sm83_regbank: table-driven write/read vectors with a
// scoreboard queue, plus hand-written inc/dec, collision, reset and swap sequences.
module tb_sm83_regbank;
  import sm83_pkg::*;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [2:0]  rd_sel, wr_sel, inc_sel;
  logic        wr_hi_we, wr_lo_we, inc_start, alt_swap;
  logic [15:0] wr_data;
  logic [1:0]  inc_mode;
  pair_t       rd_pair, al_out;
  logic        inc_busy, inc_carry;

  sm83_regbank dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .rd_sel    (rd_sel),
    .rd_pair   (rd_pair),
    .wr_sel    (wr_sel),
    .wr_hi_we  (wr_hi_we),
    .wr_lo_we  (wr_lo_we),
    .wr_data   (wr_data),
    .inc_start (inc_start),
    .inc_sel   (inc_sel),
    .inc_mode  (inc_mode),
    .inc_busy  (inc_busy),
    .inc_carry (inc_carry),
    .al_out    (al_out),
    .alt_swap  (alt_swap)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string       name;
    logic [2:0]  sel;
    logic        hi;
    logic        lo;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_push(input string name, input logic [15:0] e);
    sb_t s;
    s.name = name;
    s.exp  = e;
    sb_q.push_back(s);
  endtask

  task automatic expect_pop(input logic [15:0] act);
    sb_t s;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_underflow: got %h expected none", act);
    end else begin
      s = sb_q.pop_front();
      check(s.name, act, s.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wr_sel    = '0;
    wr_hi_we  = 1'b0;
    wr_lo_we  = 1'b0;
    wr_data   = '0;
    inc_start = 1'b0;
    inc_sel   = '0;
    inc_mode  = 2'd0;
    alt_swap  = 1'b0;
  endtask

  task automatic check_pair(input string name, input int sel, input logic [15:0] exp);
    rd_sel = 3'(sel);
    #1;
    check(name, rd_pair, exp);
  endtask

  task automatic write_pair(input int sel, input logic [15:0] d);
    wr_sel   = 3'(sel);
    wr_hi_we = 1'b1;
    wr_lo_we = 1'b1;
    wr_data  = d;
  endtask

  task automatic start_inc(input int sel, input logic [1:0] mode);
    inc_start = 1'b1;
    inc_sel   = 3'(sel);
    inc_mode  = mode;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"af_flag_mask", 3'(AF), 1'b1, 1'b1, 16'h12FF, 16'h12F0};
    vecs[1] = '{"bc_hi_only",   3'(BC), 1'b1, 1'b0, 16'hAB77, 16'hAB00};
    vecs[2] = '{"bc_lo_only",   3'(BC), 1'b0, 1'b1, 16'h1234, 16'hAB34};
    vecs[3] = '{"de_full",      3'(DE), 1'b1, 1'b1, 16'h1000, 16'h1000};
    vecs[4] = '{"sel6_ignored", 3'd6,   1'b1, 1'b1, 16'hBEEF, 16'h0000};
    vecs[5] = '{"sel7_ignored", 3'd7,   1'b1, 1'b1, 16'hCAFE, 16'h0000};
    vecs[6] = '{"hl_full",      3'(HL), 1'b1, 1'b1, 16'hFFFF, 16'hFFFF};
    vecs[7] = '{"sp_zero",      3'(SP), 1'b1, 1'b1, 16'h0000, 16'h0000};
    vecs[8] = '{"pc_full",      3'(PC), 1'b1, 1'b1, 16'hC3A5, 16'hC3A5};
    vecs[9] = '{"af_lo_masked", 3'(AF), 1'b0, 1'b1, 16'h00A7, 16'h12A0};

    clear_inputs();
    rd_sel  = '0;
    n_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) check($sformatf("reset_pair%0d", i), {13'd0, 3'(i)} & 16'h0 | rd_pair_at(i), 16'h0000);
    check("reset_busy", {15'd0, inc_busy}, 16'h0);
    check("reset_carry", {15'd0, inc_carry}, 16'h0);
    check("reset_al", al_out, 16'h0000);
    n_reset = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      wr_sel   = vecs[i].sel;
      wr_hi_we = vecs[i].hi;
      wr_lo_we = vecs[i].lo;
      wr_data  = vecs[i].data;
      expect_push(vecs[i].name, vecs[i].exp);
      step();
      clear_inputs();
      rd_sel = vecs[i].sel;
      #1;
      expect_pop(rd_pair);
    end

    write_pair(BC, 16'h5555);
    check_pair("bc_no_bypass", BC, 16'hAB34);
    step();
    clear_inputs();
    check_pair("bc_after_write", BC, 16'h5555);

    start_inc(HL, 2'd1);
    step();
    clear_inputs();
    check("hl_inc_al", al_out, 16'hFFFF);
    check("hl_inc_busy", {15'd0, inc_busy}, 16'h1);
    step();
    check_pair("hl_inc_wrap", HL, 16'h0000);
    check("hl_inc_carry", {15'd0, inc_carry}, 16'h1);
    check("hl_inc_idle", {15'd0, inc_busy}, 16'h0);

    start_inc(SP, 2'd2);
    step();
    clear_inputs();
    check("sp_dec_busy", {15'd0, inc_busy}, 16'h1);
    step();
    check_pair("sp_dec_wrap", SP, 16'hFFFF);
    check("sp_dec_carry", {15'd0, inc_carry}, 16'h1);
    start_inc(SP, 2'd3);
    step();
    clear_inputs();
    check("sp_latch_al", al_out, 16'hFFFF);
    check("sp_latch_busy", {15'd0, inc_busy}, 16'h0);
    step();
    check_pair("sp_latch_unchanged", SP, 16'hFFFF);
    check("sp_latch_carry_kept", {15'd0, inc_carry}, 16'h1);

    start_inc(DE, 2'd1);
    step();
    clear_inputs();
    wr_sel   = 3'(DE);
    wr_lo_we = 1'b1;
    wr_data  = 16'h0055;
    step();
    clear_inputs();
    check_pair("de_collision", DE, 16'h1055);
    check("de_carry_clear", {15'd0, inc_carry}, 16'h0);

    start_inc(PC, 2'd2);
    step();
    start_inc(BC, 2'd1);
    step();
    clear_inputs();
    check_pair("pc_dec", PC, 16'hC3A4);
    check("busy_start_al_kept", al_out, 16'hC3A5);
    step();
    check_pair("busy_start_ignored", BC, 16'h5555);
    check("busy_start_no_wb", {15'd0, inc_busy}, 16'h0);

    start_inc(BC, 2'd3);
    write_pair(BC, 16'h7777);
    step();
    clear_inputs();
    check("start_write_al_pre", al_out, 16'h5555);
    check_pair("start_write_bc", BC, 16'h7777);

    start_inc(6, 2'd1);
    step();
    clear_inputs();
    check("bad_sel_busy", {15'd0, inc_busy}, 16'h0);
    check("bad_sel_al", al_out, 16'h5555);

    start_inc(PC, 2'd1);
    step();
    clear_inputs();
    check("rst_mid_busy_pre", {15'd0, inc_busy}, 16'h1);
    #1;
    n_reset = 1'b0;
    #1;
    check("rst_mid_busy", {15'd0, inc_busy}, 16'h0);
    check_pair("rst_mid_pc", PC, 16'h0000);
    check("rst_mid_al", al_out, 16'h0000);
    @(negedge clk);
    n_reset = 1'b1;
    step();
    check_pair("rst_no_wb_pc", PC, 16'h0000);
    check("rst_no_wb_busy", {15'd0, inc_busy}, 16'h0);

    write_pair(BC, 16'h1111);
    step();
    clear_inputs();
    alt_swap = 1'b1;
    step();
    clear_inputs();
    write_pair(BC, 16'h2222);
    step();
    clear_inputs();
    check_pair("swap_bc_written", BC, 16'h2222);
    alt_swap = 1'b1;
    step();
    clear_inputs();
`ifdef SM83_REGBANK_ALT_EN
    check_pair("swap_bc_back", BC, 16'h1111);
`else
    check_pair("swap_bc_back", BC, 16'h2222);
`endif
    alt_swap = 1'b1;
    step();
    clear_inputs();
    check_pair("swap_bc_again", BC, 16'h2222);

    start_inc(HL, 2'd1);
    step();
    clear_inputs();
    alt_swap = 1'b1;
    step();
    clear_inputs();
    check_pair("swap_in_wb_hl", HL, 16'h0001);
    step();
`ifdef SM83_REGBANK_ALT_EN
    check_pair("swap_deferred_hl", HL, 16'h0000);
`else
    check_pair("swap_deferred_hl", HL, 16'h0001);
`endif

    check("scoreboard_empty", 16'(sb_q.size()), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic logic [15:0] rd_pair_at(input int sel);
    return dut.r_pairs[sel];
  endfunction

endmodule
